trap_ctrl: RTL
==============

# trap_ctrl

Trap initiator for the commit end of the pipeline: it detects synchronous exceptions, `mret` and enabled machine interrupts at the retiring instruction. It drains outstanding memory traffic, then issues a one-cycle trap or mret commit to the CSR file. It finally redirects fetch to the handler (`mtvec`) or return address (`mepc`), holding commit and flushing younger stages throughout.

## Interface
- No parameters; XLEN fixed at 64.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cm_valid  in  1  instruction at commit this cycle
- cm_pc  in  64  PC of commit instruction
- cm_exc  in  6  exception flags: [0] instr-misaligned, [1] illegal, [2] ebreak, [3] ecall-M, [4] load-misaligned, [5] store-misaligned
- cm_tval  in  64  faulting address / instruction bits
- cm_mret  in  1  commit instruction is `mret`
- irq_pending  in  3  {MEI, MTI, MSI}, already masked by `mie` & `mip`
- mstatus_mie  in  1  global interrupt enable
- mtvec  in  64  current `mtvec` from CSR file
- mepc  in  64  current `mepc` from CSR file
- mem_busy  in  1  data-memory transaction outstanding
- trap_valid  out  1  one-cycle trap commit to CSR file
- trap_cause  out  64  `mcause` value
- trap_epc  out  64  `mepc` value
- trap_tval  out  64  `mtval` value
- mret_valid  out  1  one-cycle `mret` commit to CSR file
- stall  out  1  hold commit stage
- flush  out  1  kill all stages younger than commit
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  64  redirect target

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT. Reset → IDLE; outputs are Moore-decoded from state and latched registers.
- Event detection happens in IDLE only, and only when cm_valid=1. Inputs are ignored in every other state.
- An interrupt event requires mstatus_mie=1 and irq_pending≠0.
- Event priority:
  1. interrupt: MEI (cause 11), then MSI (3), then MTI (7); cause bit 63 = 1; tval = 0.
  2. exception, in this order:
     - instr-misaligned (0), tval = cm_tval
     - illegal (2), tval = cm_tval
     - ebreak (3), tval = cm_pc
     - ecall-M (11), tval = 0
     - load-misaligned (4), tval = cm_tval
     - store-misaligned (6), tval = cm_tval
  3. mret.
- Exceptions and interrupts both suppress mret.
- On any event: latch kind (trap/mret), cause, epc = cm_pc and tval; go to DRAIN. The event instruction does not retire.
- DRAIN: stay while mem_busy=1; when mem_busy=0, go to COMMIT.
- COMMIT: trap kind → trap_valid=1 with the latched cause/epc/tval; mret kind → mret_valid=1. Go to REDIRECT.
- REDIRECT: redirect_valid=1, then go to IDLE.
  - trap: base = {mtvec[63:2], 2'b00}. If mtvec[1:0]==1 and the trap is an interrupt, target = base + (cause[5:0] << 2), 64-bit wrap. Otherwise target = base.
  - mret: target = {mepc[63:1], 1'b0}.
  - mtvec and mepc are sampled in REDIRECT, so a CSR update made in COMMIT is already visible.
- stall = flush = 1 in DRAIN, COMMIT and REDIRECT; 0 in IDLE.
- trap_cause, trap_epc and trap_tval read 0 whenever trap_valid=0.
- redirect_pc reads 0 whenever redirect_valid=0.

## Timing
- Reset values: state IDLE; trap_valid, mret_valid, redirect_valid, stall and flush are 0; all 64-bit outputs are 0; latched registers are 0.
- Event sampled in cycle N → DRAIN in N+1 → earliest COMMIT in N+2 → REDIRECT in N+3 → IDLE in N+4.
- Each cycle mem_busy stays high in DRAIN adds exactly one cycle of latency.
- trap_valid, mret_valid and redirect_valid are each high for exactly one cycle per event and are never high together.
- Minimum spacing between two events is 4 cycles; the next event can be sampled in cycle N+4.
- Reset asserted in any state: IDLE on the next edge, with no pending pulse emitted.
- cm_exc≠0 with cm_valid=0 is ignored.

## Test plan
- Illegal instruction, no memory traffic:
  - Stimulus: cm_valid=1, cm_exc=6'b000010, cm_pc=0x80000010, cm_tval=0xFFFFFFFF, mtvec=0x80001000, in cycle N.
  - Response: trap_valid in N+2 with cause=2, epc=0x80000010, tval=0xFFFFFFFF; redirect_pc=0x80001000 in N+3; stall=flush=1 over N+1..N+3.
- Vectored timer interrupt taken over a simultaneous ecall:
  - Stimulus: irq_pending=3'b010, mstatus_mie=1, cm_exc[3]=1, mtvec=0x80001001.
  - Response: cause=0x8000000000000007, tval=0, redirect_pc=0x8000101C.
- Interrupt masked by the global enable:
  - Stimulus: mstatus_mie=0, irq_pending=3'b100, no exception.
  - Response: state stays IDLE, and no outputs assert.
- mret:
  - Stimulus: cm_mret=1, mepc=0x80000205.
  - Response: mret_valid in N+2; redirect_pc=0x80000204 in N+3; trap_valid stays 0.
- Drain with memory busy:
  - Stimulus: store-misaligned exception with mem_busy=1 for 3 cycles from N+1.
  - Response: trap_valid in N+5 with cause=6; stall held continuously from N+1 through N+6.
- Reset mid-operation:
  - Stimulus: reset asserted during DRAIN.
  - Response: no trap_valid or redirect_valid ever asserts, and all outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/trap_ctrl.sv
// Commit-end trap initiator: catches exceptions, interrupts and mret at retirement,
// waits for memory to drain, commits to the CSR file, then redirects fetch.
module trap_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cm_valid,
  input  logic [63:0] cm_pc,
  input  logic [5:0]  cm_exc,
  input  logic [63:0] cm_tval,
  input  logic        cm_mret,
  input  logic [2:0]  irq_pending,
  input  logic        mstatus_mie,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  input  logic        mem_busy,
  output logic        trap_valid,
  output logic [63:0] trap_cause,
  output logic [63:0] trap_epc,
  output logic [63:0] trap_tval,
  output logic        mret_valid,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DRAIN    = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic        mret_kind_reg;
  logic [63:0] cause_reg, epc_reg, tval_reg;

  logic        irq_take, exc_take, event_hit;
  logic [63:0] ev_cause, ev_tval;

  assign irq_take  = mstatus_mie && (irq_pending != 3'b000);
  assign exc_take  = (cm_exc != 6'b000000);
  assign event_hit = cm_valid && (irq_take || exc_take || cm_mret);

  // Interrupts outrank exceptions; within each group the first matching entry wins.
  always_comb begin
    ev_cause = 64'd0;
    ev_tval  = 64'd0;
    if (irq_take) begin
      if (irq_pending[2])      ev_cause = {1'b1, 63'd11};
      else if (irq_pending[0]) ev_cause = {1'b1, 63'd3};
      else                     ev_cause = {1'b1, 63'd7};
    end else if (cm_exc[0]) begin
      ev_cause = 64'd0;
      ev_tval  = cm_tval;
    end else if (cm_exc[1]) begin
      ev_cause = 64'd2;
      ev_tval  = cm_tval;
    end else if (cm_exc[2]) begin
      ev_cause = 64'd3;
      ev_tval  = cm_pc;
    end else if (cm_exc[3]) begin
      ev_cause = 64'd11;
    end else if (cm_exc[4]) begin
      ev_cause = 64'd4;
      ev_tval  = cm_tval;
    end else if (cm_exc[5]) begin
      ev_cause = 64'd6;
      ev_tval  = cm_tval;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (event_hit) state_next = DRAIN;
      DRAIN:    if (!mem_busy) state_next = COMMIT;
      COMMIT:   state_next = REDIRECT;
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mret_kind_reg <= 1'b0;
      cause_reg     <= 64'd0;
      epc_reg       <= 64'd0;
      tval_reg      <= 64'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && event_hit) begin
        mret_kind_reg <= !(irq_take || exc_take);
        cause_reg     <= ev_cause;
        epc_reg       <= cm_pc;
        tval_reg      <= ev_tval;
      end
    end
  end

  logic [63:0] vector_off, trap_target, mret_target;

  // mtvec/mepc are read live in REDIRECT so a CSR write made during COMMIT is honoured.
  assign vector_off  = {56'd0, cause_reg[5:0], 2'b00};
  assign trap_target = {mtvec[63:2], 2'b00} +
                       ((mtvec[1:0] == 2'b01 && cause_reg[63]) ? vector_off : 64'd0);
  assign mret_target = {mepc[63:1], 1'b0};

  assign stall          = (state_reg != IDLE);
  assign flush          = (state_reg != IDLE);
  assign trap_valid     = (state_reg == COMMIT) && !mret_kind_reg;
  assign mret_valid     = (state_reg == COMMIT) && mret_kind_reg;
  assign redirect_valid = (state_reg == REDIRECT);
  assign trap_cause     = trap_valid ? cause_reg : 64'd0;
  assign trap_epc       = trap_valid ? epc_reg   : 64'd0;
  assign trap_tval      = trap_valid ? tval_reg  : 64'd0;
  assign redirect_pc    = redirect_valid ? (mret_kind_reg ? mret_target : trap_target) : 64'd0;

endmodule
